// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz attractor display path.
// Fixed-point format, projection selector and screen geometry.
package lorenz_pkg;

  localparam int FRAC_BITS = 20;
  localparam int FIX_W     = 27;
  localparam int COORD_W   = 12;

  typedef logic signed [FIX_W-1:0] fix7_20_t;

  typedef enum logic [1:0] {
    PROJ_XY = 2'd0,
    PROJ_XZ = 2'd1,
    PROJ_YZ = 2'd2
  } proj_e;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  // Encoding 3 is unassigned and falls back to the (x,y) plane.
  function automatic proj_e decode_proj(input logic [1:0] sel);
    case (sel)
      2'd1:    return PROJ_XZ;
      2'd2:    return PROJ_YZ;
      default: return PROJ_XY;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W-1:0] v,
    input logic signed [COORD_W-1:0] max_v
  );
    if (v < 12'sd0)
      return '0;
    else if (v > max_v)
      return max_v;
    else
      return v;
  endfunction

endpackage

// File: rtl/pix_req_fifo.sv
// Synchronous show-ahead FIFO for pixel-write requests.
// head always presents the oldest entry; pop and push may share a cycle.
module pix_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lorenz_pixel_writer.sv
// Decimates Lorenz integrator state, projects it to screen coordinates and
// queues pixel-write requests; samples that find the queue full are counted.
module lorenz_pixel_writer
  import lorenz_pkg::*;
#(
  parameter int DECIM      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int H_SHIFT    = 2,
  parameter int V_SHIFT    = 1,
  parameter int COLOR_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         proj_sel,
  input  fix7_20_t           in_x,
  input  fix7_20_t           in_y,
  input  fix7_20_t           in_z,
  // pix_valid/pix_ready: a request transfers on every edge where both are
  // high; while pix_valid is high and pix_ready low the payload is held.
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [8:0]         pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic [15:0]        drop_count
);

  localparam int CW      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ENTRY_W = 10 + 9 + COLOR_W;

  localparam logic signed [COORD_W-1:0] HALF_W = COORD_W'(SCREEN_W / 2);
  localparam logic signed [COORD_W-1:0] HALF_H = COORD_W'(SCREEN_H / 2);
  localparam logic signed [COORD_W-1:0] MAX_X  = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] MAX_Y  = COORD_W'(SCREEN_H - 1);

  logic [CW-1:0] dec_cnt;
  logic          tick;

  logic          s1_valid;
  fix7_20_t      s1_x, s1_y, s1_z;
  proj_e         s1_proj;

  fix7_20_t                  h_src, v_src;
  logic signed [6:0]         hi, vi;
  logic signed [COORD_W-1:0] hi_ext, vi_ext, px_raw, py_raw;

  logic               s2_valid;
  logic [9:0]         s2_x;
  logic [8:0]         s2_y;
  logic [COLOR_W-1:0] s2_color;
  logic [COLOR_W-1:0] color_cnt;

  logic               fifo_full, fifo_empty, pop, accept;
  logic [ENTRY_W-1:0] fifo_head;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [COLOR_W-1:0] head_color;
  logic               unused_frac;

  assign tick = enable && (dec_cnt == CW'(DECIM - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_cnt <= '0;
    end else if (tick) begin
      dec_cnt <= '0;
    end else if (enable) begin
      dec_cnt <= dec_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
      s1_proj  <= PROJ_XY;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1_x    <= in_x;
        s1_y    <= in_y;
        s1_z    <= in_z;
        s1_proj <= decode_proj(proj_sel);
      end
    end
  end

  always_comb begin
    h_src = s1_x;
    v_src = s1_y;
    case (s1_proj)
      PROJ_XZ: begin h_src = s1_x; v_src = s1_z; end
      PROJ_YZ: begin h_src = s1_y; v_src = s1_z; end
      default: begin h_src = s1_x; v_src = s1_y; end
    endcase
  end

  // Taking only the integer bits floors toward minus infinity.
  assign hi     = h_src[26:20];
  assign vi     = v_src[26:20];
  assign hi_ext = {{(COORD_W-7){hi[6]}}, hi};
  assign vi_ext = {{(COORD_W-7){vi[6]}}, vi};
  assign px_raw = HALF_W + (hi_ext <<< H_SHIFT);
  assign py_raw = HALF_H - (vi_ext <<< V_SHIFT);

  assign unused_frac = ^{s1_x[19:0], s1_y[19:0], s1_z[19:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_color  <= '0;
      color_cnt <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x      <= 10'(clamp_coord(px_raw, MAX_X));
        s2_y      <= 9'(clamp_coord(py_raw, MAX_Y));
        s2_color  <= color_cnt;
        color_cnt <= color_cnt + COLOR_W'(1);
      end
    end
  end

  assign pop    = pix_valid && pix_ready;
  assign accept = s2_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (s2_valid && !accept && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  pix_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data ({s2_x, s2_y, s2_color}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Payload is forced to zero while nothing is queued so reset reads clean.
  assign {head_x, head_y, head_color} = fifo_head;
  assign pix_valid = !fifo_empty;
  assign pix_x     = pix_valid ? head_x : '0;
  assign pix_y     = pix_valid ? head_y : '0;
  assign pix_color = pix_valid ? head_color : '0;

endmodule
